// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module  : fetch_sequencer
// Brief   : Instruction fetch FSM issuing 16-bit halves from 32-bit memory
//           words. Define FETCH_SEQ_PREFETCH_EN to add a next-word buffer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        mem_req,
  output logic [14:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_data,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  output logic [15:0] inst,
  output logic        inst_valid,
  output logic [15:0] inst_pc
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_pc, w_pc_nxt;
  logic [31:0] r_buf, w_buf_nxt;
  logic [14:0] r_drain_addr, w_drain_addr_nxt;
  logic [15:0] w_pc_inc;
  logic        w_issue;
  logic        w_req_raw;
  logic [14:0] w_next_word;

  assign w_pc_inc    = r_pc + 16'd1;
  assign w_next_word = r_pc[15:1] + 15'd1;
  assign w_issue     = (r_state == ISSUE);

`ifdef FETCH_SEQ_PREFETCH_EN
  logic [31:0] r_nxt, w_nxt_nxt;
  logic        r_nxt_vld, w_nxt_vld_nxt;
`endif

  // Outputs are forced to zero outside ISSUE so reset leaves inst/inst_pc at 0.
  always_comb begin
    inst_valid = w_issue;
    inst       = 16'h0000;
    inst_pc    = 16'h0000;
    if (w_issue) begin
      inst    = r_pc[0] ? r_buf[31:16] : r_buf[15:0];
      inst_pc = r_pc;
    end
  end

  always_comb begin
    w_req_raw = 1'b0;
    mem_addr  = r_pc[15:1];
    case (r_state)
      FETCH: w_req_raw = 1'b1;
      DRAIN: begin
        w_req_raw = 1'b1;
        mem_addr  = r_drain_addr;
      end
      ISSUE: begin
`ifdef FETCH_SEQ_PREFETCH_EN
        w_req_raw = ~r_nxt_vld;
        mem_addr  = w_next_word;
`endif
      end
      default: w_req_raw = 1'b0;
    endcase
  end

  // Gating with rst keeps the request low during reset and lets it rise
  // in the very first cycle reset is released.
  assign mem_req = rst & w_req_raw;

  always_comb begin
    w_state_nxt      = r_state;
    w_pc_nxt         = r_pc;
    w_buf_nxt        = r_buf;
    w_drain_addr_nxt = r_drain_addr;
`ifdef FETCH_SEQ_PREFETCH_EN
    w_nxt_nxt        = r_nxt;
    w_nxt_vld_nxt    = r_nxt_vld;
`endif
    case (r_state)
      FETCH: begin
        if (redirect) begin
          w_pc_nxt = redirect_pc;
          if (!mem_ack) begin
            w_state_nxt      = DRAIN;
            w_drain_addr_nxt = r_pc[15:1];
          end
        end else if (mem_ack) begin
          w_buf_nxt   = mem_data;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (redirect) begin
          w_pc_nxt    = redirect_pc;
          w_state_nxt = FETCH;
`ifdef FETCH_SEQ_PREFETCH_EN
          w_nxt_vld_nxt = 1'b0;
          if (w_req_raw && !mem_ack) begin
            w_state_nxt      = DRAIN;
            w_drain_addr_nxt = w_next_word;
          end
`endif
        end else begin
`ifdef FETCH_SEQ_PREFETCH_EN
          if (w_req_raw && mem_ack) begin
            w_nxt_nxt     = mem_data;
            w_nxt_vld_nxt = 1'b1;
          end
`endif
          if (!stall) begin
            w_pc_nxt = w_pc_inc;
            if (r_pc[0]) begin
`ifdef FETCH_SEQ_PREFETCH_EN
              // Odd half consumed: refill from the prefetched word if any.
              if (r_nxt_vld) begin
                w_buf_nxt     = r_nxt;
                w_nxt_vld_nxt = 1'b0;
              end else if (mem_ack) begin
                w_buf_nxt     = mem_data;
                w_nxt_vld_nxt = 1'b0;
              end else begin
                w_state_nxt = FETCH;
              end
`else
              w_state_nxt = FETCH;
`endif
            end
          end
        end
      end
      DRAIN: begin
        if (redirect) w_pc_nxt = redirect_pc;
        if (mem_ack) w_state_nxt = FETCH;
      end
      default: w_state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state      <= FETCH;
      r_pc         <= RESET_PC;
      r_buf        <= 32'h0;
      r_drain_addr <= 15'h0;
`ifdef FETCH_SEQ_PREFETCH_EN
      r_nxt        <= 32'h0;
      r_nxt_vld    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_pc         <= w_pc_nxt;
      r_buf        <= w_buf_nxt;
      r_drain_addr <= w_drain_addr_nxt;
`ifdef FETCH_SEQ_PREFETCH_EN
      r_nxt        <= w_nxt_nxt;
      r_nxt_vld    <= w_nxt_vld_nxt;
`endif
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module  : tb_fetch_sequencer
// Brief   : Directed self-checking bench for fetch_sequencer.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_req;
  logic [14:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_data;
  logic        stall;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic [15:0] inst;
  logic        inst_valid;
  logic [15:0] inst_pc;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  fetch_sequencer #(.RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst        (inst),
    .inst_valid  (inst_valid),
    .inst_pc     (inst_pc)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Word whose halves equal their own halfword addresses.
  function automatic logic [31:0] word_of(input logic [14:0] w);
    return {w, 1'b1, w, 1'b0};
  endfunction

  initial begin
    logic [15:0] exp_pc;
    logic        exp_v;

    rst = 1'b0; mem_ack = 1'b0; mem_data = 32'h0; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 16'h0;
    tick(); tick();
    chk("rst_req",   {31'h0, mem_req},    32'h0);
    chk("rst_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst_inst",  {16'h0, inst},       32'h0);
    chk("rst_pc",    {16'h0, inst_pc},    32'h0);

    // First cycle out of reset: request word 0, acked immediately.
    rst = 1'b1; #1;
    chk("first_req",  {31'h0, mem_req}, 32'h1);
    chk("first_addr", {17'h0, mem_addr}, 32'h0);
    mem_ack = 1'b1; mem_data = 32'hBBBB_AAAA;
    tick();
    mem_ack = 1'b0;
    chk("i0_valid", {31'h0, inst_valid}, 32'h1);
    chk("i0_inst",  {16'h0, inst},       32'hAAAA);
    chk("i0_pc",    {16'h0, inst_pc},    32'h0000);

    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_valid", {31'h0, inst_valid}, 32'h1);
      chk("stall_inst",  {16'h0, inst},       32'hAAAA);
      chk("stall_pc",    {16'h0, inst_pc},    32'h0000);
    end
    stall = 1'b0;
    tick();
    chk("i1_inst", {16'h0, inst},    32'hBBBB);
    chk("i1_pc",   {16'h0, inst_pc}, 32'h0001);
    tick();
    chk("w1_valid", {31'h0, inst_valid}, 32'h0);
    chk("w1_req",   {31'h0, mem_req},    32'h1);
    chk("w1_addr",  {17'h0, mem_addr},   32'h1);

    // Redirect during FETCH with ack two cycles later.
    redirect = 1'b1; redirect_pc = 16'h0013;
    tick();
    redirect = 1'b0;
    chk("drain_req",   {31'h0, mem_req},    32'h1);
    chk("drain_addr",  {17'h0, mem_addr},   32'h1);
    chk("drain_valid", {31'h0, inst_valid}, 32'h0);
    tick();
    chk("drain2_addr", {17'h0, mem_addr}, 32'h1);
    mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    chk("rd_valid", {31'h0, inst_valid}, 32'h0);
    chk("rd_req",   {31'h0, mem_req},    32'h1);
    chk("rd_addr",  {17'h0, mem_addr},   32'h9);
    mem_data = 32'h2222_1111;
    tick();
    mem_ack = 1'b0;
    chk("odd_inst", {16'h0, inst},    32'h2222);
    chk("odd_pc",   {16'h0, inst_pc}, 32'h0013);
    tick();
    chk("odd_next_valid", {31'h0, inst_valid}, 32'h0);
    chk("odd_next_addr",  {17'h0, mem_addr},   32'hA);

    // Redirect coinciding with ack in FETCH, then wrap at 16'hFFFF.
    redirect = 1'b1; redirect_pc = 16'hFFFF; mem_ack = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    redirect = 1'b0;
    chk("ff_valid", {31'h0, inst_valid}, 32'h0);
    chk("ff_addr",  {17'h0, mem_addr},   32'h7FFF);
    mem_data = 32'hCCCC_9999;
    tick();
    mem_ack = 1'b0;
    chk("ff_inst", {16'h0, inst},    32'hCCCC);
    chk("ff_pc",   {16'h0, inst_pc}, 32'hFFFF);
    tick();
    chk("wrap_req",  {31'h0, mem_req},  32'h1);
    chk("wrap_addr", {17'h0, mem_addr}, 32'h0);
    mem_ack = 1'b1; mem_data = 32'h4444_3333;
    tick();
    chk("wrap_inst", {16'h0, inst},    32'h3333);
    chk("wrap_pc",   {16'h0, inst_pc}, 32'h0000);

    // Redirect beats stall in ISSUE.
    redirect = 1'b1; redirect_pc = 16'h0100; stall = 1'b1; mem_data = 32'hDEAD_BEEF;
    tick();
    redirect = 1'b0; stall = 1'b0;
    chk("ri_valid", {31'h0, inst_valid}, 32'h0);
    chk("ri_addr",  {17'h0, mem_addr},   32'h80);
    mem_data = word_of(mem_addr);
    tick();
    chk("r100_pc", {16'h0, inst_pc}, 32'h0100);

    // Throughput with ack every cycle.
    exp_pc = 16'h0101;
    for (int i = 0; i < 9; i++) begin
      mem_data = word_of(mem_addr);
      tick();
`ifdef FETCH_SEQ_PREFETCH_EN
      exp_v = 1'b1;
`else
      exp_v = ((i % 3) != 1);
`endif
      chk("tp_valid", {31'h0, inst_valid}, {31'h0, exp_v});
      if (exp_v) begin
        chk("tp_pc",   {16'h0, inst_pc}, {16'h0, exp_pc});
        chk("tp_inst", {16'h0, inst},    {16'h0, exp_pc});
        exp_pc = exp_pc + 16'd1;
      end
    end

    // Reset mid-stream abandons everything; new request begins at RESET_PC.
    rst = 1'b0; mem_ack = 1'b0;
    tick();
    chk("rst2_req",   {31'h0, mem_req},    32'h0);
    chk("rst2_valid", {31'h0, inst_valid}, 32'h0);
    chk("rst2_pc",    {16'h0, inst_pc},    32'h0);
    rst = 1'b1; #1;
    chk("rst2_addr", {17'h0, mem_addr}, 32'h0);
    mem_ack = 1'b1; mem_data = 32'h5678_1234;
    tick();
    mem_ack = 1'b0;
    chk("rst2_inst", {16'h0, inst}, 32'h1234);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter RESET_PC, default 16'h0000, is the instruction address loaded on reset.
REQ-002 Port clk  input  1  is the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  is the reset: synchronous, active-low.
REQ-004 Port mem_req  output  1  is the instruction-memory read request.
REQ-005 Port mem_addr  output  15  is the word address, equal to pc[15:1] of the fetched word.
REQ-006 Port mem_ack  input  1  means mem_data is valid for the current request this cycle.
REQ-007 Port mem_data  input  32  holds two instructions: [15:0] is the even (first), [31:16] is the odd (second).
REQ-008 Port stall  input  1  means downstream is not accepting inst this cycle.
REQ-009 Port redirect  input  1  means a jump or taken branch loads redirect_pc.
REQ-010 Port redirect_pc  input  16  is the new instruction (halfword) address.
REQ-011 Port inst  output  16  is the issued instruction.
REQ-012 Port inst_valid  output  1  qualifies inst and inst_pc.
REQ-013 Port inst_pc  output  16  is the address of inst.

Function
REQ-014 The FSM SHALL have states FETCH, ISSUE and DRAIN; pc is a 16-bit instruction address.
REQ-015 In FETCH, mem_req=1 and mem_addr=pc[15:1], held stable until mem_ack; mem_req SHALL never drop before ack.
REQ-016 On mem_ack in FETCH, mem_data SHALL be latched into the word buffer and the FSM SHALL enter ISSUE (inst_valid=1 on the next cycle, latency 1).
REQ-017 In ISSUE, inst = buffer[15:0] when pc[0]=0 and buffer[31:16] when pc[0]=1; inst_valid=1; inst_pc=pc.
REQ-018 In ISSUE with stall=1, pc, inst, inst_valid and inst_pc SHALL hold.
REQ-019 In ISSUE with stall=0, pc SHALL increment; pc[0]=0 SHALL remain in ISSUE, and pc[0]=1 SHALL go to FETCH.
REQ-020 pc increment SHALL wrap 16'hFFFF -> 16'h0000, so the fetch wraps to word 0.
REQ-021 redirect SHALL have priority over stall and increment: pc<=redirect_pc, and inst_valid=0 the next cycle.
REQ-022 A redirect in ISSUE, or in FETCH coinciding with mem_ack, SHALL go to FETCH and discard the buffer and any acked data.
REQ-023 A redirect in FETCH without mem_ack SHALL go to DRAIN: mem_req stays 1 at the old address until ack, the data is discarded, then FETCH at the new pc.
REQ-024 A redirect during DRAIN SHALL update pc only and remain in DRAIN.
REQ-025 A redirect to an odd pc SHALL fetch the word and issue only the high half before the next fetch.
REQ-026 inst_valid SHALL be 0 in FETCH and DRAIN.

Reset
REQ-027 With rst=0 at a clock edge: pc=RESET_PC, state=FETCH, buffer=0, inst=0, inst_pc=0, inst_valid=0, and mem_req=0 while rst=0.
REQ-028 Reset mid-transaction SHALL abandon any outstanding request; an ack on the first cycle after reset applies to the new request.
REQ-029 The first mem_req=1 SHALL appear in the first cycle with rst=1.

Configuration
REQ-030 Macro FETCH_SEQ_PREFETCH_EN, when defined, SHALL add a second 32-bit next-word buffer with its own valid bit.
REQ-031 With the macro defined, while ISSUE and next-word empty, the next fetch (pc[15:1]+1) SHALL be requested; on issuing an odd half with next-word valid, the FSM SHALL move the next word into the buffer and stay in ISSUE (zero bubble).
REQ-032 With the macro defined, redirect SHALL invalidate next-word; an outstanding prefetch SHALL be handled per REQ-023.
REQ-033 Without the macro, fetch SHALL occur only per REQ-019, costing at least one bubble cycle per word.

Verification
REQ-034 Bench SHALL cover: reset with RESET_PC=0, ack the next cycle with mem_data=32'hBBBB_AAAA -> inst 16'hAAAA @pc0, then 16'hBBBB @pc1, then mem_req with mem_addr=1.
REQ-035 Bench SHALL cover: stall held 3 cycles on 16'hAAAA -> inst, inst_pc and inst_valid stable, pc unchanged.
REQ-036 Bench SHALL cover: redirect to 16'h0013 during FETCH with ack delayed 2 cycles -> DRAIN, old data discarded, then mem_addr=15'h0009, and only the high half issued @pc 16'h0013.
REQ-037 Bench SHALL cover: pc=16'hFFFF with no stall -> next mem_addr=15'h0000, pc=16'h0000.
REQ-038 Bench SHALL cover: with FETCH_SEQ_PREFETCH_EN, ack every cycle, no stall -> inst_valid continuously 1 across word boundaries; without the macro -> one idle cycle per word.
